// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface instr_fetch_if;
    logic [31:0] imAddr;
    logic        imReq;
    logic        imValid;
    logic [31:0] imData;

    modport master (
        output imAddr,
        output imReq,
        input  imValid,
        input  imData
    );

    modport slave (
        input  imAddr,
        input  imReq,
        output imValid,
        output imData
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over the req/valid bus, holds the word for decode.
// Optional macro ALIGN_CHECK_EN: misaligned next-PC traps into a sticky ERR state.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rstN,
    instr_fetch_if.master im,
    output logic [31:0]   instr,
    output logic          instrValid,
    output logic [31:0]   pc,
    output logic [31:0]   linkAddr,
    input  logic          commit,
    input  logic [1:0]    pcSrcCtrl,
    input  logic [25:0]   jAddr,
    input  logic [31:0]   imm,
    input  logic [31:0]   jrTarget,
    input  logic          aluZero,
    output logic          fetchErr
);

`ifdef ALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE, FETCH, READY, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;
`endif

    typedef enum logic [1:0] {PC_INC4 = 2'd0, PC_J = 2'd1, PC_JR = 2'd2, PC_BNE = 2'd3} pc_src_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] pc4;
    logic [31:0] target;
    logic [31:0] nextPc;
`ifdef ALIGN_CHECK_EN
    logic        err_q, err_d;
    logic        misaligned;
`endif

    always_comb begin
        pc4 = pc_q + 32'd4;
        case (pcSrcCtrl)
            PC_J:    target = {pc4[31:28], jAddr, 2'b00};
            PC_JR:   target = jrTarget;
            PC_BNE:  target = aluZero ? pc4 : pc4 + {imm[29:0], 2'b00};
            default: target = pc4;
        endcase
    end

`ifdef ALIGN_CHECK_EN
    assign nextPc     = target;
    assign misaligned = |target[1:0];
    assign fetchErr   = err_q;
`else
    assign nextPc     = {target[31:2], 2'b00};
    assign fetchErr   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
`ifdef ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (im.imValid) begin
                    instr_d = im.imData;
                    valid_d = 1'b1;
                    state_d = READY;
                end
            end
            READY: begin
                if (commit && valid_q) begin
                    valid_d = 1'b0;
`ifdef ALIGN_CHECK_EN
                    // A bad target leaves the PC at the offending instruction.
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        pc_d    = nextPc;
                        state_d = FETCH;
                    end
`else
                    pc_d    = nextPc;
                    state_d = FETCH;
`endif
                end
            end
`ifdef ALIGN_CHECK_EN
            ERR: valid_d = 1'b0;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Request is a pure state decode so asynchronous reset drops it at once.
    assign im.imReq    = (state_q == FETCH);
    assign im.imAddr   = pc_q;
    assign instr       = instr_q;
    assign instrValid  = valid_q;
    assign pc          = pc_q;
    assign linkAddr    = pc4;

endmodule
